// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register bank.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, COMMAND, DATA} spi_slave_state_t;

    localparam logic SPI_READ        = 1'b1;
    localparam logic SPI_WRITE       = 1'b0;
    localparam int   SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_register_bank_if.sv
// SPI pins, completed-write port and host read port of the SPI slave register bank.
interface spi_slave_register_bank_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15
);
    logic                     serial_clock;
    logic                     chip_select;
    logic                     serial_in;
    logic                     clock_polarity;
    logic                     clock_phase;
    logic                     serial_out;
    logic                     busy;
    logic                     write_strobe;
    logic [ADDRESS_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     write_unmapped;
    logic                     frame_error;
    logic [ADDRESS_WIDTH-1:0] host_address;
    logic [DATA_WIDTH-1:0]    host_read_data;

    modport slave (
        input  serial_clock, chip_select, serial_in, clock_polarity, clock_phase, host_address,
        output serial_out, busy, write_strobe, write_address, write_data, write_unmapped,
               frame_error, host_read_data
    );

    modport master (
        output serial_clock, chip_select, serial_in, clock_polarity, clock_phase, host_address,
        input  serial_out, busy, write_strobe, write_address, write_data, write_unmapped,
               frame_error, host_read_data
    );
endinterface

// File: rtl/spi_slave_input_sync.sv
// Brings the SPI pins into the clock domain and turns serial_clock transitions
// into sample/shift strobes according to CPOL/CPHA.
module spi_slave_input_sync
    import spi_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic serial_clock,
    input  logic chip_select,
    input  logic serial_in,
    input  logic clock_polarity,
    input  logic clock_phase,
    output logic serial_in_sync,
    output logic select_fall,
    output logic select_rise,
    output logic sample_edge,
    output logic shift_edge
);
    logic [SPI_SYNC_STAGES-1:0] sclk_sync, cs_sync, sin_sync;
    logic sclk_prev, cs_prev;
    logic sclk_s, cs_s, sclk_rise, sclk_fall, lead_edge, trail_edge;

    // Select syncs reset to deselected so no phantom frame starts after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sin_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SPI_SYNC_STAGES-2:0], serial_clock};
            cs_sync   <= {cs_sync[SPI_SYNC_STAGES-2:0], chip_select};
            sin_sync  <= {sin_sync[SPI_SYNC_STAGES-2:0], serial_in};
            sclk_prev <= sclk_sync[SPI_SYNC_STAGES-1];
            cs_prev   <= cs_sync[SPI_SYNC_STAGES-1];
        end
    end

    assign sclk_s         = sclk_sync[SPI_SYNC_STAGES-1];
    assign cs_s           = cs_sync[SPI_SYNC_STAGES-1];
    assign serial_in_sync = sin_sync[SPI_SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign sclk_fall   = ~sclk_s & sclk_prev;
    assign select_fall = ~cs_s & cs_prev;
    assign select_rise = cs_s & ~cs_prev;

    assign lead_edge   = clock_polarity ? sclk_fall : sclk_rise;
    assign trail_edge  = clock_polarity ? sclk_rise : sclk_fall;
    assign sample_edge = clock_phase ? trail_edge : lead_edge;
    assign shift_edge  = clock_phase ? lead_edge : trail_edge;
endmodule

// File: rtl/spi_slave_register_bank.sv
// SPI slave decoding rw/address/data frames with burst auto-increment into a
// register bank, plus a registered host read port.
module spi_slave_register_bank
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 15,
    parameter int REGISTER_DEPTH = 16
) (
    input  logic clock,
    input  logic reset,
    spi_slave_register_bank_if.slave bus
);
    localparam int CMD_BITS = ADDRESS_WIDTH + 1;
    localparam int MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
    localparam int CW       = $clog2(MAX_BITS);
    localparam int IW       = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1;

    spi_slave_state_t         state, state_next;
    logic [CW-1:0]            bit_count;
    logic [ADDRESS_WIDTH-1:0] cmd_shift, address;
    logic [DATA_WIDTH-2:0]    data_shift;
    logic [DATA_WIDTH-1:0]    tx_shift, data_word;
    logic [CMD_BITS-1:0]      cmd_word;
    logic                     rw, serial_out, frame_error;
    logic                     pend_valid;
    logic [ADDRESS_WIDTH-1:0] pend_address, write_address;
    logic [DATA_WIDTH-1:0]    pend_data, write_data, host_read_data;
    logic                     write_strobe, write_unmapped;
    logic                     sin, select_fall, select_rise, sample_edge, shift_edge;
    logic                     cmd_done, word_done;
    logic [DATA_WIDTH-1:0]    regs [REGISTER_DEPTH];

    spi_slave_input_sync u_sync (
        .clock          (clock),
        .reset          (reset),
        .serial_clock   (bus.serial_clock),
        .chip_select    (bus.chip_select),
        .serial_in      (bus.serial_in),
        .clock_polarity (bus.clock_polarity),
        .clock_phase    (bus.clock_phase),
        .serial_in_sync (sin),
        .select_fall    (select_fall),
        .select_rise    (select_rise),
        .sample_edge    (sample_edge),
        .shift_edge     (shift_edge)
    );

    function automatic logic is_mapped(input logic [ADDRESS_WIDTH-1:0] a);
        return {1'b0, a} < (ADDRESS_WIDTH+1)'(REGISTER_DEPTH);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] reg_read(input logic [ADDRESS_WIDTH-1:0] a);
        return is_mapped(a) ? regs[IW'(a)] : '0;
    endfunction

    assign cmd_word  = {cmd_shift, sin};
    assign data_word = {data_shift, sin};
    assign cmd_done  = (state == COMMAND) && sample_edge && (bit_count == CW'(CMD_BITS - 1));
    assign word_done = (state == DATA) && sample_edge && (bit_count == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (select_fall) state_next = COMMAND;
            COMMAND: if (select_rise) state_next = IDLE;
                     else if (cmd_done) state_next = DATA;
            DATA:    if (select_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath; completed writes go through one pending stage before the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_count      <= '0;
            cmd_shift      <= '0;
            data_shift     <= '0;
            tx_shift       <= '0;
            address        <= '0;
            rw             <= SPI_WRITE;
            serial_out     <= 1'b0;
            frame_error    <= 1'b0;
            pend_valid     <= 1'b0;
            pend_address   <= '0;
            pend_data      <= '0;
            write_strobe   <= 1'b0;
            write_unmapped <= 1'b0;
            write_address  <= '0;
            write_data     <= '0;
        end else begin
            pend_valid     <= 1'b0;
            frame_error    <= 1'b0;
            write_strobe   <= pend_valid;
            write_unmapped <= pend_valid & ~is_mapped(pend_address);
            if (pend_valid) begin
                write_address <= pend_address;
                write_data    <= pend_data;
            end

            if (state == IDLE) begin
                bit_count  <= '0;
                tx_shift   <= '0;
                serial_out <= 1'b0;
            end else if (select_rise) begin
                frame_error <= (bit_count != '0);
                bit_count   <= '0;
                serial_out  <= 1'b0;
            end else begin
                if (shift_edge) begin
                    serial_out <= tx_shift[DATA_WIDTH-1];
                    tx_shift   <= tx_shift << 1;
                end
                if (sample_edge && state == COMMAND) begin
                    cmd_shift <= cmd_word[ADDRESS_WIDTH-1:0];
                    bit_count <= bit_count + CW'(1);
                    if (cmd_done) begin
                        bit_count <= '0;
                        rw        <= cmd_word[CMD_BITS-1];
                        address   <= cmd_word[ADDRESS_WIDTH-1:0];
                        tx_shift  <= (cmd_word[CMD_BITS-1] == SPI_READ)
                                     ? reg_read(cmd_word[ADDRESS_WIDTH-1:0]) : '0;
                    end
                end
                if (sample_edge && state == DATA) begin
                    data_shift <= data_word[DATA_WIDTH-2:0];
                    bit_count  <= bit_count + CW'(1);
                    if (word_done) begin
                        bit_count <= '0;
                        address   <= address + 1'b1;
                        if (rw == SPI_READ) begin
                            tx_shift <= reg_read(address + 1'b1);
                        end else begin
                            pend_valid   <= 1'b1;
                            pend_address <= address;
                            pend_data    <= data_word;
                        end
                    end
                end
            end
        end
    end

    // Host read samples the bank before the same-edge write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGISTER_DEPTH; i++) regs[i] <= '0;
            host_read_data <= '0;
        end else begin
            host_read_data <= reg_read(bus.host_address);
            if (write_strobe && !write_unmapped) regs[IW'(write_address)] <= write_data;
        end
    end

    assign bus.serial_out     = serial_out;
    assign bus.busy           = (state != IDLE);
    assign bus.write_strobe   = write_strobe;
    assign bus.write_address  = write_address;
    assign bus.write_data     = write_data;
    assign bus.write_unmapped = write_unmapped;
    assign bus.frame_error    = frame_error;
    assign bus.host_read_data = host_read_data;
endmodule

// File: tb/tb_spi_slave_register_bank.sv
// Directed bench: drives SPI frames in all four modes and checks strobes, reads and resets.
module tb_spi_slave_register_bank;
    import spi_pkg::*;

    localparam int H = 6;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
        logic        u;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int base = 0;
    int ferr_n = 0;
    int ferr_base = 0;
    logic busy_mid = 1'b0;
    logic [127:0] tx, rx;
    wr_t st_q[$];

    spi_slave_register_bank_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(15)) bus ();

    spi_slave_register_bank #(.DATA_WIDTH(16), .ADDRESS_WIDTH(15), .REGISTER_DEPTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.write_strobe) st_q.push_back('{a: bus.write_address, d: bus.write_data, u: bus.write_unmapped});
        if (bus.frame_error) ferr_n = ferr_n + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [14:0] a, input logic [15:0] d, input logic u);
        if (st_q.size() > base + k) begin
            check({tag, "_addr"}, 64'(st_q[base+k].a), 64'(a));
            check({tag, "_data"}, 64'(st_q[base+k].d), 64'(d));
            check({tag, "_unmapped"}, 64'(st_q[base+k].u), 64'(u));
        end else begin
            check({tag, "_present"}, 64'(st_q.size()), 64'(base + k + 1));
        end
    endtask

    task automatic host_read(input string tag, input logic [14:0] a, input logic [15:0] exp);
        bus.host_address = a;
        wait_cycles(2);
        check(tag, 64'(bus.host_read_data), 64'(exp));
    endtask

    // Bits go out from t[nbits-1] down to t[0]; MISO samples accumulate into r LSB-last.
    task automatic spi_xfer(input logic [1:0] mode, input int nbits, input logic [127:0] t,
                            input bit hold_select, output logic [127:0] r);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        r = '0;
        bus.clock_polarity = cpol;
        bus.clock_phase    = cpha;
        bus.serial_clock   = cpol;
        wait_cycles(8);
        bus.chip_select = 1'b0;
        if (!cpha) bus.serial_in = t[nbits-1];
        wait_cycles(H);
        busy_mid = bus.busy;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (cpha) bus.serial_in = t[i];
            bus.serial_clock = ~cpol;
            if (!cpha) r = {r[126:0], bus.serial_out};
            wait_cycles(H);
            bus.serial_clock = cpol;
            if (cpha) r = {r[126:0], bus.serial_out};
            else if (i > 0) bus.serial_in = t[i-1];
            wait_cycles(H);
        end
        if (!hold_select) begin
            bus.chip_select = 1'b1;
            wait_cycles(10);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_serial_out"}, 64'(bus.serial_out), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_write_strobe"}, 64'(bus.write_strobe), 64'd0);
        check({tag, "_write_unmapped"}, 64'(bus.write_unmapped), 64'd0);
        check({tag, "_frame_error"}, 64'(bus.frame_error), 64'd0);
        check({tag, "_write_address"}, 64'(bus.write_address), 64'd0);
        check({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
        check({tag, "_host_read_data"}, 64'(bus.host_read_data), 64'd0);
    endtask

    initial begin
        bus.serial_clock   = 1'b0;
        bus.chip_select    = 1'b1;
        bus.serial_in      = 1'b0;
        bus.clock_polarity = 1'b0;
        bus.clock_phase    = 1'b0;
        bus.host_address   = '0;
        wait_cycles(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        wait_cycles(4);

        // Mode 0 single write to 3
        base = st_q.size(); ferr_base = ferr_n;
        tx = '0; tx[31:0] = {SPI_WRITE, 15'd3, 16'hA5C3};
        spi_xfer(2'd0, 32, tx, 1'b0, rx);
        check("m0_busy_mid", 64'(busy_mid), 64'd1);
        check("m0_busy_after", 64'(bus.busy), 64'd0);
        check("m0_strobes", 64'(st_q.size() - base), 64'd1);
        chk_wr("m0_wr", 0, 15'd3, 16'hA5C3, 1'b0);
        check("m0_ferr", 64'(ferr_n - ferr_base), 64'd0);
        host_read("m0_host3", 15'd3, 16'hA5C3);

        // Mode 3 read of 3
        base = st_q.size();
        tx = '0; tx[31:0] = {SPI_READ, 15'd3, 16'h0000};
        spi_xfer(2'd3, 32, tx, 1'b0, rx);
        check("m3_read3", 64'(rx[15:0]), 64'hA5C3);
        check("m3_strobes", 64'(st_q.size() - base), 64'd0);

        // Mode 1 burst write crossing the end of the map
        base = st_q.size();
        tx = '0; tx[63:0] = {SPI_WRITE, 15'd14, 16'h1111, 16'h2222, 16'h3333};
        spi_xfer(2'd1, 64, tx, 1'b0, rx);
        check("m1_strobes", 64'(st_q.size() - base), 64'd3);
        chk_wr("m1_wr0", 0, 15'd14, 16'h1111, 1'b0);
        chk_wr("m1_wr1", 1, 15'd15, 16'h2222, 1'b0);
        chk_wr("m1_wr2", 2, 15'd16, 16'h3333, 1'b1);
        host_read("m1_host14", 15'd14, 16'h1111);
        host_read("m1_host15", 15'd15, 16'h2222);
        host_read("m1_host16", 15'd16, 16'h0000);
        tx = '0; tx[31:0] = {SPI_READ, 15'd16, 16'h0000};
        spi_xfer(2'd1, 32, tx, 1'b0, rx);
        check("m1_read16", 64'(rx[15:0]), 64'h0000);

        // Mode 2: seed register 0, then burst read wrapping from 0x7FFF
        tx = '0; tx[31:0] = {SPI_WRITE, 15'd0, 16'hBEEF};
        spi_xfer(2'd2, 32, tx, 1'b0, rx);
        host_read("m2_host0", 15'd0, 16'hBEEF);
        base = st_q.size();
        tx = '0; tx[47:0] = {SPI_READ, 15'h7FFF, 32'h0};
        spi_xfer(2'd2, 48, tx, 1'b0, rx);
        check("m2_word0", 64'(rx[31:16]), 64'h0000);
        check("m2_word1_wrap", 64'(rx[15:0]), 64'hBEEF);
        check("m2_strobes", 64'(st_q.size() - base), 64'd0);

        // Write cut off after 10 data bits
        base = st_q.size(); ferr_base = ferr_n;
        tx = '0; tx[25:0] = {SPI_WRITE, 15'd14, 10'h2A5};
        spi_xfer(2'd0, 26, tx, 1'b0, rx);
        check("ferr_pulses", 64'(ferr_n - ferr_base), 64'd1);
        check("ferr_strobes", 64'(st_q.size() - base), 64'd0);
        host_read("ferr_host14", 15'd14, 16'h1111);

        // Reset during command bits, then a clean frame
        ferr_base = ferr_n;
        tx = '0; tx[6:0] = {SPI_WRITE, 6'h00};
        spi_xfer(2'd0, 7, tx, 1'b1, rx);
        check("rst_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        wait_cycles(1);
        check_outputs_zero("midrst");
        bus.chip_select  = 1'b1;
        bus.serial_clock = 1'b0;
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(4);
        check("rst_busy_after", 64'(bus.busy), 64'd0);
        host_read("rst_host3", 15'd3, 16'h0000);
        host_read("rst_host14", 15'd14, 16'h0000);
        host_read("rst_host0", 15'd0, 16'h0000);
        check("rst_ferr", 64'(ferr_n - ferr_base), 64'd0);
        base = st_q.size();
        tx = '0; tx[31:0] = {SPI_WRITE, 15'd5, 16'h1234};
        spi_xfer(2'd0, 32, tx, 1'b0, rx);
        check("post_strobes", 64'(st_q.size() - base), 64'd1);
        chk_wr("post_wr", 0, 15'd5, 16'h1234, 1'b0);
        host_read("post_host5", 15'd5, 16'h1234);
        tx = '0; tx[31:0] = {SPI_READ, 15'd5, 16'h0000};
        spi_xfer(2'd0, 32, tx, 1'b0, rx);
        check("post_read5", 64'(rx[15:0]), 64'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_register_bank.md
# spi_slave_register_bank

Parametrised SPI slave terminating frames produced by `spi_master`: one read/write bit, an address, then one or more data words with burst auto-increment. Supports all four CPOL/CPHA modes and owns a register bank of configurable depth, with a registered host read port for fabric logic. Sits on the device side of the SPI link and is the synthesizable successor to the slave simulation model.

## Interface
- `DATA_WIDTH`, 16, data word width in bits.
- `ADDRESS_WIDTH`, 15, frame address width in bits.
- `REGISTER_DEPTH`, 16, number of implemented registers; addresses `0..REGISTER_DEPTH-1` are mapped. Must satisfy `1 <= REGISTER_DEPTH <= 2**ADDRESS_WIDTH`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_clock`  in  1  SPI clock, asynchronous to `clock`.
- `chip_select`  in  1  active-low frame select.
- `serial_in`  in  1  MOSI.
- `clock_polarity`  in  1  CPOL; stable while `chip_select` is low.
- `clock_phase`  in  1  CPHA; stable while `chip_select` is low.
- `serial_out`  out  1  MISO, MSB first; 0 when not selected.
- `busy`  out  1  high while a frame is in progress.
- `write_strobe`  out  1  one-cycle pulse per completed write word.
- `write_address`  out  ADDRESS_WIDTH  address of the completed write word.
- `write_data`  out  DATA_WIDTH  completed write word.
- `write_unmapped`  out  1  qualifies `write_strobe`: address not mapped.
- `frame_error`  out  1  one-cycle pulse when a frame ends mid-field.
- `host_address`  in  ADDRESS_WIDTH  host read address.
- `host_read_data`  out  DATA_WIDTH  register at `host_address`, one cycle late; 0 if unmapped.

## Operation
- Frame, MSB first: `rw` (1 = read, 0 = write), `address[ADDRESS_WIDTH-1:0]`, then data words until `chip_select` rises.
- The leading edge is the transition away from the CPOL idle level. CPHA=0: sample on leading edges, shift on trailing edges, and the first bit is valid from select. CPHA=1: shift on leading edges, sample on trailing edges.
- States:
  - IDLE -> COMMAND on synchronised `chip_select` fall.
  - COMMAND -> DATA after `1+ADDRESS_WIDTH` samples.
  - DATA -> DATA after each `DATA_WIDTH` samples.
  - Any state -> IDLE on `chip_select` rise.
- Read: on the last address sample, load register[address], or 0 if unmapped, into the output shift register. Its MSB appears at the next shift edge. After each word, increment the address and reload.
- Write: on each completed word, pulse `write_strobe` with `write_address` and `write_data`. If the address is mapped, update the register on the same cycle. If unmapped, assert `write_unmapped` and leave registers unchanged.
- Address increment wraps modulo `2**ADDRESS_WIDTH`.
- `frame_error` pulses if `chip_select` rises in COMMAND with any bit received, or in DATA with `0 < bits < DATA_WIDTH`. The partial word is discarded with no `write_strobe`.
- Reset, including mid-frame: state IDLE, all registers 0.
- Reset values of outputs: `serial_out`, `busy`, `write_strobe`, `write_unmapped`, `frame_error` all 0; `write_address`, `write_data`, `host_read_data` all 0.

## Timing
- `serial_clock`, `chip_select` and `serial_in` pass through 2-flop synchronisers, then edge detection. Detection latency is 3 `clock` cycles after the pin transition.
- Requirements on the SPI side:
  - `serial_clock` high and low phases each >= 4 `clock` cycles, i.e. spi_master `divider >= 3`.
  - `chip_select` fall-to-first-edge and last-edge-to-rise each >= 4 cycles.
- `serial_out` updates within 4 `clock` cycles of the shift edge.
- `write_strobe` asserts 4 cycles after the final data sample edge at the pin. The register value is visible on `host_read_data` 2 cycles after the strobe.
- Host read vs simultaneous write to the same address: `host_read_data` returns the old value, i.e. read-before-write.
- `busy` rises 3 cycles after `chip_select` falls and falls 3 cycles after it rises.

## Structure
- Package `spi_pkg`:
  - state enum `spi_slave_state_t` {IDLE, COMMAND, DATA};
  - `SPI_READ = 1'b1`, `SPI_WRITE = 1'b0`;
  - synchroniser depth constant `SPI_SYNC_STAGES = 2`.
- Sub-module `spi_slave_input_sync`: synchronises the three SPI inputs and emits `select_fall`, `select_rise`, `sample_edge` and `shift_edge`, given CPOL/CPHA.
- Top level holds the FSM, bit counter, shift registers and register bank.

## Test plan
- Mode 0: write addr 3, data 0xA5C3 -> one `write_strobe` with address 3, data 0xA5C3, `write_unmapped` = 0; `host_address = 3` gives 0xA5C3.
- Mode 3: read addr 3 after the write above -> master `read_data` = 0xA5C3, no `write_strobe`.
- Mode 1: burst write at addr 14 of 0x1111, 0x2222, 0x3333 -> strobes at 14, 15, 16. The strobe at 16 has `write_unmapped` = 1. Registers 14 and 15 are updated; a later read of 16 returns 0.
- Mode 2: burst read at 0x7FFF, 2 words -> 0 then register 0; address wraps to 0.
- `chip_select` rises after 10 data bits of a write -> `frame_error` pulse, no `write_strobe`, register unchanged.
- `reset` asserted mid-frame at bit 7 of COMMAND -> all outputs 0, registers 0, `busy` low. The next full frame completes correctly.
